// File: rtl/alu_result_fifo_pkg.sv
// Shared ALU types: opcode enum and the packed result record carried through the FIFO.
package alu_result_fifo_pkg;

    typedef enum logic [3:0] {
        OpAdd  = 4'h0,
        OpSub  = 4'h1,
        OpAnd  = 4'h2,
        OpOr   = 4'h3,
        OpXor  = 4'h4,
        OpNot  = 4'h5,
        OpShl  = 4'h6,
        OpShr  = 4'h7,
        OpInc  = 4'h8,
        OpDec  = 4'h9,
        OpPass = 4'hA
    } alu_op_e;

    typedef struct packed {
        logic [15:0] result;
        logic        c_out;
        logic        z_flag;
        logic [3:0]  op_code;
    } alu_res_t;

    localparam int unsigned AluResW = $bits(alu_res_t);

    function automatic alu_res_t pack_res(input logic [15:0] result, input logic c_out,
                                          input logic z_flag, input logic [3:0] op_code);
        alu_res_t r;
        r.result  = result;
        r.c_out   = c_out;
        r.z_flag  = z_flag;
        r.op_code = op_code;
        return r;
    endfunction

endpackage

// File: rtl/alu_result_ram.sv
// Result storage: one synchronous write port, one asynchronous read port.
module alu_result_ram
    import alu_result_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  alu_res_t      wdata_i,
    input  logic [AW-1:0] raddr_i,
    output alu_res_t      rdata_o
);

    alu_res_t mem_q [DEPTH];

    // Contents are never reset; validity is tracked by the FIFO count.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/alu_result_fifo.sv
// First-word fall-through FIFO for ALU results with a saturating overflow-attempt counter.
module alu_result_fifo
    import alu_result_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_result,
    input  logic             in_c_out,
    input  logic             in_z_flag,
    input  logic [3:0]       in_op_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_result,
    output logic             out_c_out,
    output logic             out_z_flag,
    output logic [3:0]       out_op_code,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic [7:0]       ovf_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       ovf_q, ovf_d;
    logic             push, pop;
    alu_res_t         wdata, rdata;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign wdata = pack_res(in_result, in_c_out, in_z_flag, in_op_code);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push) wr_ptr_d = next_ptr(wr_ptr_q);
        if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // Rejected push attempts, saturating.
        if (in_valid && full && ovf_q != 8'hFF) ovf_d = ovf_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    alu_result_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (wdata),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata)
    );

    assign out_result  = rdata.result;
    assign out_c_out   = rdata.c_out;
    assign out_z_flag  = rdata.z_flag;
    assign out_op_code = rdata.op_code;
    assign count       = count_q;
    assign ovf_cnt     = ovf_q;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed self-checking bench for alu_result_fifo (DEPTH=8).
module tb_alu_result_fifo;
    import alu_result_fifo_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [15:0] in_result;
    logic        in_c_out, in_z_flag;
    logic [3:0]  in_op_code;
    logic        out_valid, out_ready;
    logic [15:0] out_result;
    logic        out_c_out, out_z_flag;
    logic [3:0]  out_op_code;
    logic [3:0]  count;
    logic        full, empty;
    logic [7:0]  ovf_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_result_fifo #(
        .DEPTH (8),
        .CNT_W (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_result   (in_result),
        .in_c_out    (in_c_out),
        .in_z_flag   (in_z_flag),
        .in_op_code  (in_op_code),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_c_out   (out_c_out),
        .out_z_flag  (out_z_flag),
        .out_op_code (out_op_code),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .ovf_cnt     (ovf_cnt)
    );

    typedef struct {
        logic        iv;
        logic        ordy;
        logic [15:0] res;
        logic [3:0]  ecount;
        logic        evalid;
        logic [15:0] eres;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [15:0] v);
        in_valid  = 1'b1;
        in_result = v;
        step();
        in_valid  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b0, 16'h00FF, 4'd1, 1'b1, 16'h00FF};
        vecs[1] = '{1'b1, 1'b0, 16'h1234, 4'd2, 1'b1, 16'h00FF};
        vecs[2] = '{1'b1, 1'b1, 16'h5678, 4'd2, 1'b1, 16'h1234};
        vecs[3] = '{1'b0, 1'b1, 16'h0000, 4'd1, 1'b1, 16'h5678};
        vecs[4] = '{1'b0, 1'b1, 16'h0000, 4'd0, 1'b0, 16'h0000};
        vecs[5] = '{1'b0, 1'b1, 16'h0000, 4'd0, 1'b0, 16'h0000};
        vecs[6] = '{1'b1, 1'b1, 16'hA5A5, 4'd1, 1'b1, 16'hA5A5};
        vecs[7] = '{1'b0, 1'b0, 16'h0000, 4'd1, 1'b1, 16'hA5A5};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_result = '0; in_c_out = 1'b0; in_z_flag = 1'b0; in_op_code = '0;
        step();
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_ovf", 32'(ovf_cnt), 32'd0);
        rst = 1'b0;
        step();

        // Table: first row also covers the single-push latency case with sideband fields.
        for (int i = 0; i < 8; i++) begin
            in_valid   = vecs[i].iv;
            out_ready  = vecs[i].ordy;
            in_result  = vecs[i].res;
            in_c_out   = (i == 0);
            in_z_flag  = 1'b0;
            in_op_code = (i == 0) ? 4'h3 : 4'h0;
            step();
            check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].ecount));
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].evalid));
            check($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].ecount == 0));
            if (vecs[i].evalid)
                check($sformatf("vec%0d_result", i), 32'(out_result), 32'(vecs[i].eres));
            if (i == 0) begin
                check("vec0_c_out", 32'(out_c_out), 32'd1);
                check("vec0_z_flag", 32'(out_z_flag), 32'd0);
                check("vec0_op_code", 32'(out_op_code), 32'h3);
            end
        end
        in_valid = 1'b0; in_c_out = 1'b0; in_op_code = '0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("drain_empty", 32'(empty), 32'd1);

        // Fill to full, then attempt 3 more pushes.
        for (int i = 1; i <= 8; i++) push_one(16'(i));
        check("fill_full", 32'(full), 32'd1);
        check("fill_in_ready", 32'(in_ready), 32'd0);
        check("fill_count", 32'(count), 32'd8);
        check("fill_head", 32'(out_result), 32'h0001);
        in_valid = 1'b1; in_result = 16'hDEAD;
        for (int i = 0; i < 3; i++) step();
        in_valid = 1'b0;
        check("ovf_3", 32'(ovf_cnt), 32'd3);
        check("ovf_count", 32'(count), 32'd8);
        check("ovf_head_stable", 32'(out_result), 32'h0001);

        // Drain from full in order.
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("pop%0d", i), 32'(out_result), 32'(i));
            step();
        end
        out_ready = 1'b0;
        check("pop_empty", 32'(empty), 32'd1);
        check("pop_out_valid", 32'(out_valid), 32'd0);

        // Simultaneous push/pop at count=4 across pointer wrap.
        for (int i = 0; i < 4; i++) push_one(16'(100 + i));
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_result = 16'(104 + i);
            check($sformatf("stream%0d_head", i), 32'(out_result), 32'(100 + i));
            step();
            check($sformatf("stream%0d_count", i), 32'(count), 32'd4);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("stream_final_head", 32'(out_result), 32'd120);

        // Asynchronous reset with 5 entries buffered.
        push_one(16'd124);
        check("pre_rst_count", 32'(count), 32'd5);
        #2;
        rst = 1'b1;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_empty", 32'(empty), 32'd1);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_ovf", 32'(ovf_cnt), 32'd0);
        step();
        rst = 1'b0;
        push_one(16'hBEEF);
        check("post_rst_valid", 32'(out_valid), 32'd1);
        check("post_rst_head", 32'(out_result), 32'hBEEF);
        check("post_rst_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Saturation of the overflow counter.
        for (int i = 0; i < 8; i++) push_one(16'(200 + i));
        in_valid = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            step();
            if (k == 254) check("sat_254", 32'(ovf_cnt), 32'd254);
            if (k == 255) check("sat_255", 32'(ovf_cnt), 32'd255);
        end
        in_valid = 1'b0;
        check("sat_300", 32'(ovf_cnt), 32'd255);
        check("sat_count", 32'(count), 32'd8);
        check("sat_head", 32'(out_result), 32'd200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_result_fifo.md
ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

Interface
REQ-001: Parameter DEPTH, default 8, number of result entries; SHALL be a power of two, 2..16.
REQ-002: Parameter CNT_W, default $clog2(DEPTH)+1, width of the occupancy count.
REQ-003: clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004: rst  input  1  asynchronous, active-high reset.
REQ-005: in_valid  input  1  upstream ALU result is valid this cycle.
REQ-006: in_ready  output  1  block accepts a result this cycle.
REQ-007: in_result  input  16  ALU Result.
REQ-008: in_c_out  input  1  ALU C_out.
REQ-009: in_z_flag  input  1  ALU Z_flag.
REQ-010: in_op_code  input  4  op_code tag travelling with the result.
REQ-011: out_valid  output  1  head entry is valid.
REQ-012: out_ready  input  1  downstream consumer accepts the head entry.
REQ-013: out_result, out_c_out, out_z_flag, out_op_code  output  16/1/1/4  head entry fields.
REQ-014: count  output  CNT_W  current occupancy, 0..DEPTH.
REQ-015: full, empty  output  1 each  count==DEPTH and count==0.
REQ-016: ovf_cnt  output  8  number of cycles with in_valid=1 and in_ready=0, saturating at 255.

Function
REQ-017: A push SHALL occur exactly when in_valid && in_ready; a pop exactly when out_valid && out_ready.
REQ-018: in_ready SHALL equal !full, combinationally from registered state, with no dependence on out_ready (no bypass when full).
REQ-019: out_valid SHALL equal !empty; the out_* fields SHALL present the oldest entry (first-word fall-through).
REQ-020: Latency: a push into an empty FIFO at edge N SHALL present out_valid=1 with that entry's data after edge N.
REQ-021: Push and pop in the same cycle SHALL leave count unchanged, advance both pointers, and preserve order.
REQ-022: Read and write pointers SHALL wrap from DEPTH-1 to 0; full/empty SHALL be derived from count, not from pointer equality alone.
REQ-023: Pop while empty and push while full SHALL be impossible by REQ-017; the storage and pointers SHALL NOT change in those cycles.
REQ-024: ovf_cnt SHALL increment by 1 on every cycle with in_valid=1 and full=1, hold at 255, and otherwise hold.
REQ-025: out_* fields SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026: When empty, out_* data values are don't-care; the bench SHALL NOT check them.

Reset
REQ-027: While rst=1: pointers=0, count=0, empty=1, full=0, in_ready=1, out_valid=0, ovf_cnt=0; storage contents need not be cleared.
REQ-028: Reset asserted mid-operation SHALL discard all buffered entries immediately (asynchronously); the first push after deassertion SHALL be the first entry popped.

Structure
REQ-029: The shared ALU package SHALL hold the 4-bit opcode enum and a packed result struct {result[15:0], c_out, z_flag, op_code[3:0]} (22 bits) used for storage and by the bench.
REQ-030: Storage SHALL be a single sub-module alu_result_ram (DEPTH x 22, one synchronous write port, one asynchronous read port); control, pointers, count and ovf_cnt SHALL live in alu_result_fifo.

Verification
REQ-031: Reset then push {0x00FF,c=1,z=0,op=0x3} with out_ready=0 -> next cycle out_valid=1, out_result=0x00FF, out_c_out=1, out_op_code=0x3, count=1, empty=0.
REQ-032: Push 8 results 0x0001..0x0008 with out_ready=0 -> full=1, in_ready=0, count=8; hold in_valid=1 for 3 more cycles -> ovf_cnt=3, contents unchanged.
REQ-033: From full, out_ready=1 for 8 cycles -> pops return 0x0001..0x0008 in order, then empty=1, out_valid=0.
REQ-034: With count=4, in_valid=1 and out_ready=1 for 20 cycles using incrementing data -> count stays 4, output sequence strictly in push order across pointer wrap.
REQ-035: With count=5, assert rst for 1 cycle mid-stream -> count=0, empty=1 immediately; next push 0xBEEF is the next value popped.
REQ-036: Hold in_valid=1 while full for 300 cycles -> ovf_cnt saturates at 255 and stays.
